// File: rtl/floating_point_dv_pkg.sv
// ---------------------------------------------------------------------------
// fp_div_pkg
// Shared definitions for the single-precision floating-point divider:
// FSM state encoding, IEEE-754 constants, mantissa iteration count and a
// helper that classifies an operand as zero / infinity / NaN.
// No ports (package).
// ---------------------------------------------------------------------------
package fp_div_pkg;

    localparam int unsigned BIAS      = 127;
    localparam logic [31:0] QNAN      = 32'h7FC0_0000;
    localparam int unsigned DIV_ITERS = 25;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } fp_div_state_e;

    typedef struct packed {
        logic isZero;
        logic isInf;
        logic isNan;
    } fp_class_t;

    // Denormals (exponent 0, nonzero fraction) are treated as zero, so an
    // exponent of 0 alone is enough to call the operand zero.
    function automatic fp_class_t classifyOperand(input logic [31:0] x);
        fp_class_t c;
        c.isZero = (x[30:23] == 8'h00);
        c.isInf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        c.isNan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        return c;
    endfunction

endpackage

// File: rtl/floating_point_dv_if.sv
// ---------------------------------------------------------------------------
// floating_point_dv_if
// Bundles the divider's request and response signals.
//   start        : begin a divide (only honoured while idle)
//   a, b         : dividend / divisor, IEEE-754 single
//   result       : registered quotient
//   overflow     : quotient saturated to infinity
//   underflow    : quotient flushed to signed zero
//   div_by_zero  : finite nonzero dividend over zero
//   busy         : divider is not idle
//   done         : one-cycle pulse, result and flags valid
// master modport drives the request, slave modport is the divider side.
// ---------------------------------------------------------------------------
interface floating_point_dv_if;
    import fp_div_pkg::*;

    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;
    logic        busy;
    logic        done;

    modport master (
        output start, a, b,
        input  result, overflow, underflow, div_by_zero, busy, done
    );

    modport slave (
        input  start, a, b,
        output result, overflow, underflow, div_by_zero, busy, done
    );

endinterface

// File: rtl/floating_point_dv_divider.sv
// ---------------------------------------------------------------------------
// sequential_divider
// Restoring radix-2 mantissa divider, one quotient bit per clock,
// DIV_ITERS iterations. Quotient bit 24 carries weight 1, so
// o_quotient = floor(i_dividend * 2^24 / i_divisor).
//   clk, rst     : clock, synchronous active-high reset
//   i_start      : load operands and restart (overrides a run in progress)
//   i_dividend   : 24-bit mantissa with hidden one
//   i_divisor    : 24-bit mantissa with hidden one
//   o_quotient   : 25-bit quotient
//   o_last       : the coming edge performs the final iteration
//   o_done       : one-cycle pulse once the quotient is complete
// ---------------------------------------------------------------------------
module sequential_divider
    import fp_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [23:0] i_dividend,
    input  logic [23:0] i_divisor,
    output logic [24:0] o_quotient,
    output logic        o_last,
    output logic        o_done
);

    logic [25:0]      r_rem;
    logic [23:0]      r_div;
    logic [24:0]      r_quot;
    logic [CNT_W-1:0] r_count;
    logic             r_running;
    logic             r_done;

    logic [25:0]      w_divExt;
    logic [25:0]      w_diff;
    logic             w_ge;
    logic [25:0]      w_nextRem;

    // Trial subtraction: keep the difference when the divisor fits,
    // otherwise restore the partial remainder unchanged.
    always_comb begin
        w_divExt  = {2'b00, r_div};
        w_ge      = (r_rem >= w_divExt);
        w_diff    = r_rem - w_divExt;
        w_nextRem = w_ge ? w_diff : r_rem;
    end

    // The partial remainder stays below the divisor after each step, so
    // shifting left one place never loses a set bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem     <= '0;
            r_div     <= '0;
            r_quot    <= '0;
            r_count   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem     <= {2'b00, i_dividend};
                r_div     <= i_divisor;
                r_quot    <= '0;
                r_count   <= '0;
                r_running <= 1'b1;
            end else if (r_running) begin
                r_rem   <= {w_nextRem[24:0], 1'b0};
                r_quot  <= {r_quot[23:0], w_ge};
                r_count <= r_count + CNT_W'(1);
                if (r_count == CNT_W'(DIV_ITERS - 1)) begin
                    r_running <= 1'b0;
                    r_done    <= 1'b1;
                end
            end
        end
    end

    assign o_quotient = r_quot;
    assign o_last     = r_running && (r_count == CNT_W'(DIV_ITERS - 1));
    assign o_done     = r_done;

endmodule

// File: rtl/floating_point_dv.sv
// ---------------------------------------------------------------------------
// floating_point_dv
// IEEE-754 single-precision divider: a / b with truncating rounding,
// flush-to-zero of denormal inputs and underflowing results.
// Special operands finish in one DIV cycle; normal operands run the
// 25-step mantissa divider, then normalise in NORM.
//   clk          : clock, all state on the rising edge
//   rst          : synchronous active-high reset
//   bus (slave)  : start/a/b request, result/flags/busy/done response
// ---------------------------------------------------------------------------
module floating_point_dv
    import fp_div_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    floating_point_dv_if.slave  bus
);

    fp_div_state_e     r_state;
    fp_div_state_e     w_nextState;

    logic [31:0]       r_opA;
    logic [31:0]       r_opB;
    logic [31:0]       r_result;
    logic              r_overflow;
    logic              r_underflow;
    logic              r_divByZero;

    logic              w_accept;
    logic [24:0]       w_quotient;
    logic              w_divLast;
    logic              w_divDone;

    fp_class_t         w_classA;
    fp_class_t         w_classB;
    logic              w_sign;
    logic              w_special;
    logic              w_specialDbz;
    logic [31:0]       w_specialResult;

    logic signed [9:0] w_expCalc;
    logic [22:0]       w_normFrac;
    logic [31:0]       w_normResult;
    logic              w_normOverflow;
    logic              w_normUnderflow;

    assign w_accept = (r_state == ST_IDLE) && bus.start;

    // The divider loads straight from the bus on the accepting edge so its
    // iteration counter clears in the same edge the operands are latched.
    sequential_divider u_divider (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_accept),
        .i_dividend ({1'b1, bus.a[22:0]}),
        .i_divisor  ({1'b1, bus.b[22:0]}),
        .o_quotient (w_quotient),
        .o_last     (w_divLast),
        .o_done     (w_divDone)
    );

    // Special-operand decode, checked in priority order. An infinite
    // dividend over zero is infinity but not a divide-by-zero, because the
    // flag is reserved for a finite nonzero dividend.
    always_comb begin
        w_classA        = classifyOperand(r_opA);
        w_classB        = classifyOperand(r_opB);
        w_sign          = r_opA[31] ^ r_opB[31];
        w_special       = 1'b1;
        w_specialDbz    = 1'b0;
        w_specialResult = QNAN;
        if (w_classA.isNan || w_classB.isNan) begin
            w_specialResult = QNAN;
        end else if ((w_classA.isZero && w_classB.isZero) ||
                     (w_classA.isInf && w_classB.isInf)) begin
            w_specialResult = QNAN;
        end else if (w_classB.isZero && !w_classA.isInf) begin
            w_specialResult = {w_sign, 8'hFF, 23'd0};
            w_specialDbz    = 1'b1;
        end else if (w_classA.isInf) begin
            w_specialResult = {w_sign, 8'hFF, 23'd0};
        end else if (w_classA.isZero || w_classB.isInf) begin
            w_specialResult = {w_sign, 31'd0};
        end else begin
            w_special = 1'b0;
        end
    end

    // Normalisation: a quotient of at least 1 keeps the biased exponent
    // difference, one below 1 shifts left one place and loses one from it.
    // The exponent is evaluated signed in 10 bits so both saturation
    // directions can be detected.
    always_comb begin
        w_normFrac      = w_quotient[24] ? w_quotient[23:1] : w_quotient[22:0];
        w_expCalc       = $signed({2'b00, r_opA[30:23]} - {2'b00, r_opB[30:23]} +
                                  (w_quotient[24] ? 10'(BIAS) : 10'(BIAS - 1)));
        w_normOverflow  = 1'b0;
        w_normUnderflow = 1'b0;
        w_normResult    = {w_sign, w_expCalc[7:0], w_normFrac};
        if (w_expCalc >= 10'sd255) begin
            w_normResult   = {w_sign, 8'hFF, 23'd0};
            w_normOverflow = 1'b1;
        end else if (w_expCalc <= 10'sd0) begin
            w_normResult    = {w_sign, 31'd0};
            w_normUnderflow = 1'b1;
        end
    end

    // State register; reset wins over everything including a pending start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. DIV leaves early for special operands; otherwise it
    // moves to NORM on the edge that performs the final mantissa iteration.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_nextState = ST_DIV;
                end
            end
            ST_DIV: begin
                if (w_special) begin
                    w_nextState = ST_DONE;
                end else if (w_divLast) begin
                    w_nextState = ST_NORM;
                end
            end
            ST_NORM: begin
                if (w_divDone) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Operand capture and result/flag registers. Flags drop when a new
    // operation is accepted and are only raised together with the result
    // they describe; the result itself holds until it is overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opA       <= '0;
            r_opB       <= '0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_divByZero <= 1'b0;
        end else if (w_accept) begin
            r_opA       <= bus.a;
            r_opB       <= bus.b;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_divByZero <= 1'b0;
        end else if ((r_state == ST_DIV) && w_special) begin
            r_result    <= w_specialResult;
            r_divByZero <= w_specialDbz;
        end else if ((r_state == ST_NORM) && w_divDone) begin
            r_result    <= w_normResult;
            r_overflow  <= w_normOverflow;
            r_underflow <= w_normUnderflow;
        end
    end

    assign bus.result      = r_result;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;
    assign bus.div_by_zero = r_divByZero;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_floating_point_dv.sv
// ---------------------------------------------------------------------------
// tb_floating_point_dv
// Self-checking bench for floating_point_dv: directed cases followed by
// random operands, each compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_floating_point_dv;

    logic clk = 1'b0;
    logic rst;

    floating_point_dv_if bus();

    floating_point_dv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checkCount = 0;
    int failCount  = 0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Safety net so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference quotient from the written rules: classify, apply the special
    // table, else integer-divide the mantissas scaled by 2^24 and normalise.
    function automatic void refDivide(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] res, output logic ov,
                                      output logic un, output logic dbz,
                                      output logic special);
        int    ea, eb, e;
        longint fa, fb, q, frac;
        bit    sgn, aZ, bZ, aI, bI, aN, bN;
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        fa  = longint'(a[22:0]);
        fb  = longint'(b[22:0]);
        sgn = a[31] ^ b[31];
        aZ  = (ea == 0);
        bZ  = (eb == 0);
        aI  = (ea == 255) && (fa == 0);
        bI  = (eb == 255) && (fb == 0);
        aN  = (ea == 255) && (fa != 0);
        bN  = (eb == 255) && (fb != 0);
        res = 32'd0; ov = 1'b0; un = 1'b0; dbz = 1'b0; special = 1'b1;
        if (aN || bN || (aZ && bZ) || (aI && bI)) begin
            res = 32'h7FC00000;
        end else if (bZ && !aI) begin
            res = {sgn, 8'hFF, 23'd0};
            dbz = 1'b1;
        end else if (aI) begin
            res = {sgn, 8'hFF, 23'd0};
        end else if (aZ || bI) begin
            res = {sgn, 31'd0};
        end else begin
            special = 1'b0;
            q = ((fa + 64'd8388608) * 64'd16777216) / (fb + 64'd8388608);
            if (q >= 64'd16777216) begin
                frac = (q - 64'd16777216) / 2;
                e    = ea - eb + 127;
            end else begin
                frac = q - 64'd8388608;
                e    = ea - eb + 126;
            end
            if (e >= 255) begin
                res = {sgn, 8'hFF, 23'd0};
                ov  = 1'b1;
            end else if (e <= 0) begin
                res = {sgn, 31'd0};
                un  = 1'b1;
            end else begin
                res = {sgn, 8'(e), 23'(frac)};
            end
        end
    endfunction

    // Runs one divide: pulses start, optionally re-pulses start at edge
    // N+pulseAt, waits a bounded time for done and checks latency, result,
    // flags, the single-cycle done pulse and result hold.
    task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB,
                                 input string tag, input int pulseAt);
        logic [31:0] expRes;
        logic        expOv, expUn, expDbz, isSpec;
        int          cycles;
        refDivide(opA, opB, expRes, expOv, expUn, expDbz, isSpec);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = opA;
        bus.b     = opB;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~opA;
        bus.b     = ~opB;
        cycles    = 0;
        checkOutput({tag, " busy"}, 32'(bus.busy), 32'd1);
        while (!bus.done && cycles < 100) begin
            bus.start = (cycles == pulseAt - 1);
            @(negedge clk);
            cycles++;
        end
        bus.start = 1'b0;
        checkOutput({tag, " latency"}, 32'(cycles), isSpec ? 32'd1 : 32'd26);
        checkOutput({tag, " result"}, bus.result, expRes);
        checkOutput({tag, " flags"},
                    {29'd0, bus.overflow, bus.underflow, bus.div_by_zero},
                    {29'd0, expOv, expUn, expDbz});
        @(negedge clk);
        checkOutput({tag, " donePulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
        checkOutput({tag, " hold"}, bus.result, expRes);
    endtask

    // Random operand biased toward interesting classes.
    function automatic logic [31:0] randOperand();
        logic [31:0] x;
        int          cls;
        x   = $urandom;
        cls = $urandom_range(0, 9);
        case (cls)
            0: x[30:0]  = 31'd0;
            1: x[30:0]  = {8'hFF, 23'd0};
            2: begin x[30:23] = 8'hFF; x[22] = 1'b1; end
            3: begin x[30:23] = 8'h00; x[0] = 1'b1; end
            4: x[30:23] = 8'($urandom_range(240, 254));
            5: x[30:23] = 8'($urandom_range(1, 15));
            default: x[30:23] = 8'($urandom_range(1, 254));
        endcase
        return x;
    endfunction

    // Main sequence.
    initial begin
        int doneSeen;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset result", bus.result, 32'd0);
        checkOutput("reset status",
                    {27'd0, bus.overflow, bus.underflow, bus.div_by_zero, bus.busy, bus.done},
                    32'd0);

        applyStimulus(32'h40C00000, 32'h40000000, "six/two", 0);
        checkOutput("six/two literal", bus.result, 32'h40400000);
        applyStimulus(32'h3F800000, 32'h40400000, "one/three", 0);
        checkOutput("one/three literal", bus.result, 32'h3EAAAAAA);
        applyStimulus(32'h3F800000, 32'h00000000, "one/zero", 0);
        checkOutput("one/zero literal", bus.result, 32'h7F800000);
        applyStimulus(32'h00000000, 32'h00000000, "zero/zero", 0);
        checkOutput("zero/zero literal", bus.result, 32'h7FC00000);
        applyStimulus(32'h7F000000, 32'h3E800000, "overflow", 0);
        checkOutput("overflow literal", bus.result, 32'h7F800000);
        applyStimulus(32'h00800000, 32'h4B000000, "underflow", 0);
        checkOutput("underflow literal", bus.result, 32'h00000000);
        applyStimulus(32'hFF800000, 32'h40000000, "neginf/two", 0);
        applyStimulus(32'hC0C00000, 32'h40000000, "restart ignored", 10);
        checkOutput("restart literal", bus.result, 32'hC0400000);

        // Abort a normal divide with reset at edge N+12.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h40C00000;
        bus.b     = 32'h40000000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort status",
                    {27'd0, bus.overflow, bus.underflow, bus.div_by_zero, bus.busy, bus.done},
                    32'd0);
        checkOutput("abort result", bus.result, 32'd0);
        doneSeen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done) doneSeen++;
        end
        checkOutput("abort no done", 32'(doneSeen), 32'd0);
        applyStimulus(32'h3F800000, 32'h40400000, "after abort", 0);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(randOperand(), randOperand(), $sformatf("rand%0d", i), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/floating_point_dv.md
FLOATING_POINT_DV -- requirements
Module: floating_point_dv

Interface
REQ-001 Parameter: none; IEEE-754 single precision only, all widths fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin a divide; sampled only in IDLE.
REQ-005 a  input  32  dividend, IEEE-754 single.
REQ-006 b  input  32  divisor, IEEE-754 single.
REQ-007 result  output  32  quotient a/b, registered, held until next start is accepted.
REQ-008 overflow  output  1  result exponent saturated to infinity.
REQ-009 underflow  output  1  result flushed to signed zero.
REQ-010 div_by_zero  output  1  finite nonzero a divided by zero.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  single-cycle pulse; result and flags are valid in that cycle.

Function
REQ-013 FSM states: IDLE, DIV, NORM, DONE; DONE always returns to IDLE on the next edge.
REQ-014 Start acceptance: at edge N, IDLE with start=1 latches a and b, clears the iteration counter, and moves to DIV.
REQ-015 Start while busy is ignored; the operand registers do not change.
REQ-016 Special cases are classified in the first DIV cycle; if special, the edge N+1 registers the special result and moves to DONE.
REQ-017 Input classification:
- exponent 0 means zero; denormal inputs are flushed to zero.
- exponent 255 with fraction 0 means infinity.
- exponent 255 with nonzero fraction means NaN.
REQ-018 Special results, in priority order:
- any NaN -> 0x7FC00000.
- 0/0 or inf/inf -> 0x7FC00000.
- finite nonzero/0 -> {sign, 0xFF, 0}, div_by_zero=1.
- inf/finite -> {sign, 0xFF, 0}.
- 0/x or finite/inf -> {sign, 31'b0}.
REQ-019 Result sign SHALL be sign_a XOR sign_b in all non-NaN cases.
REQ-020 Mantissa division: restoring radix-2, one quotient bit per DIV cycle, 25 iterations.
- produces q[24:0] with q[24] of weight 1.
- dividend is {1,frac_a}, divisor is {1,frac_b}.
REQ-021 After the 25th iteration (edge N+25) the FSM moves to NORM; edge N+26 registers the result and moves to DONE.
REQ-022 Latency: done is high in the cycle after edge N+26 for normal operands, and in the cycle after edge N+1 for special operands.
REQ-023 Exponent arithmetic uses a 10-bit signed value E.
- if q[24]=1: fraction = q[23:1], E = exp_a - exp_b + 127.
- otherwise: fraction = q[22:0], E = exp_a - exp_b + 126.
REQ-024 Rounding is truncation (round toward zero); no sticky or round bits are kept.
REQ-025 E >= 255 -> {sign, 0xFF, 0} with overflow=1.
REQ-026 E <= 0 -> {sign, 31'b0} with underflow=1; no denormal outputs are produced.
REQ-027 Flags are cleared when a new start is accepted, then set only with their result.

Reset
REQ-028 rst=1 at any edge, including mid-division, SHALL force IDLE and set result, all flags, busy and done to 0.
REQ-029 rst has priority over start in the same cycle; no done pulse is produced for an aborted operation.

Structure
REQ-030 Shared package fp_div_pkg holds:
- the FSM state enum;
- BIAS=127;
- QNAN=32'h7FC00000;
- the iteration count 25.
REQ-031 The mantissa iteration is a sub-module, sequential_divider: 24-bit operands, start/done handshake, 25-bit quotient, same clk and rst.

Verification
REQ-032 0x40C00000 / 0x40000000 (6.0/2.0) -> result 0x40400000, done in the cycle after edge N+26, all flags 0.
REQ-033 0x3F800000 / 0x40400000 (1.0/3.0) -> result 0x3EAAAAAA (truncated).
REQ-034 0x3F800000 / 0x00000000 -> result 0x7F800000, div_by_zero=1, done in the cycle after edge N+1; 0x00000000 / 0x00000000 -> 0x7FC00000.
REQ-035 0x7F000000 / 0x3E800000 -> result 0x7F800000, overflow=1; 0x00800000 / 0x4B000000 -> result 0x00000000, underflow=1.
REQ-036 Start pulsed again at edge N+10 -> ignored, first result unchanged.
REQ-037 rst at edge N+12 -> busy=0 next cycle and no done pulse; a following start completes correctly.
